countdown_request_arb: RTL and testbench
========================================

Name: countdown_request_arb

Overview:
- Initiator side of the frame-countdown timer interface.
- Accepts one-shot delay requests from N game clients (spells, cooldowns, respawns) and serialises them onto the single shared countdown timer.
- Issues the one-cycle request_start pulse with requested_time, waits for the timer's one-cycle expiry pulse, then routes that expiry back to the owning client as a one-cycle done pulse.
- A frame-based watchdog recovers the arbiter if the expiry pulse never arrives.

Parameters:
- N_CLIENTS, 4, number of requesting clients, range 2..8.
- WD_MARGIN, 2, extra frames the watchdog allows beyond the requested delay.

Ports:
- clk  in  1  system clock.
- resetN  in  1  reset.
- startOfFrame  in  1  one-cycle frame strobe; same strobe the countdown timer uses.
- client_req  in  N_CLIENTS  per-client one-cycle request pulse.
- client_time  in  4*N_CLIENTS  per-client delay in frames; client i occupies bits [4i+3:4i].
- timer_done  in  1  expiry pulse from the countdown timer.
- request_start  out  1  one-cycle start pulse to the countdown timer.
- requested_time  out  4  delay presented to the timer; valid while request_start=1.
- client_done  out  N_CLIENTS  one-hot, one-cycle completion pulse to the owning client.
- client_pending  out  N_CLIENTS  client has an outstanding request, either queued or active.
- busy  out  1  high in ISSUE and WAIT.
- timeout_err  out  1  one-cycle pulse when the watchdog aborts a request.

Behaviour:
- Reset and clocking:
  - Reset resetN, asynchronous, active-low; clock clk.
  - On reset, all outputs are 0, all pending bits and latched times are 0, state = IDLE, last_grant = N_CLIENTS-1, watchdog = 0.
  - Reset mid-operation drops all requests silently; no done or error pulse is generated.
- Request capture:
  - client_req[i]=1 while pending[i]=0: set pending[i] and latch time[i] = client_time[i] on the same edge.
  - client_req[i]=1 while pending[i]=1: ignored. The latched time is not overwritten.
- States:
  - IDLE: if any pending bit is set, pick the first set bit in round-robin order, starting at last_grant+1 and wrapping modulo N_CLIENTS. Store it as grant and go to ISSUE. If no bit is set, stay in IDLE.
  - ISSUE: exactly one cycle. request_start=1 and requested_time=time[grant]. Load watchdog = time[grant] + WD_MARGIN as a 5-bit value with no overflow (max 15+2=17). Go to WAIT.
  - WAIT, expiry: on timer_done=1, pulse client_done[grant]=1 for one cycle, clear pending[grant], set last_grant = grant, go to IDLE.
  - WAIT, watchdog: else on startOfFrame=1, if watchdog==0 then pulse timeout_err for one cycle, clear pending[grant], set last_grant = grant, go to IDLE with no client_done; otherwise decrement the watchdog.
- Latency:
  - Pending bit set in cycle t (idle arbiter) -> grant at edge t+1 -> request_start high in cycle t+2.
  - client_done is registered and appears the cycle after timer_done.
- Boundary cases:
  - timer_done in IDLE or ISSUE is ignored.
  - timer_done and watchdog expiry in the same cycle: done wins, no timeout_err.
  - client_req[grant] in the cycle pending[grant] clears: the new request wins. pending stays 1 and time is re-latched from the new client_time.
  - time=0 is legal; the timer expires with no frame strobe needed.
  - Only one request is in flight at a time; request_start never fires while busy.
  - client_done and timeout_err are never high together. At most one client_done bit is set per cycle.
- Output duties:
  - client_pending reflects the pending register directly.
  - busy = (state != IDLE).

Test Plan:
- Single request: client_req[1] with time=3. Expect request_start in cycle t+2 with requested_time=3. Model timer_done after 3 frames -> client_done=4'b0010 one cycle later, pending[1] cleared, busy falls.
- Round-robin: clients 0, 2 and 3 request in the same cycle with last_grant=0. Expect grant order 2, 3, 0, each with its own latched time. Each client_done follows the matching timer_done.
- Watchdog: client 0 with time=2 and timer_done never asserted. Expect timeout_err on the 5th startOfFrame after ISSUE (2+2 decrements, then the zero check). Expect pending[0]=0, no client_done, and the next pending client issued.
- Re-request and ignore: client 2 pulses req with time=5 and then again with time=9 while pending. Expect requested_time=5. A req on the done cycle with time=7 re-arms, and a second issue shows requested_time=7.
- Spurious and simultaneous: timer_done in IDLE -> no output activity. timer_done coinciding with watchdog expiry -> client_done only.
- Reset mid-WAIT: deassert resetN during WAIT. Expect all outputs 0 immediately, and no pulses after release until a new client_req.

Source files
------------

// File: rtl/countdown_request_arb.sv
// Serialises one-shot delay requests from N clients onto a single shared
// frame-countdown timer, routing each expiry back to its owner with a watchdog.
module countdown_request_arb #(
  parameter int unsigned N_CLIENTS = 4,
  parameter int unsigned WD_MARGIN = 2
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic [N_CLIENTS-1:0]   client_req,
  input  logic [4*N_CLIENTS-1:0] client_time,
  input  logic                   timer_done,
  output logic                   request_start,
  output logic [3:0]             requested_time,
  output logic [N_CLIENTS-1:0]   client_done,
  output logic [N_CLIENTS-1:0]   client_pending,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int unsigned IDX_W  = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int unsigned TIME_W = 4;
  localparam int unsigned WD_W   = 5;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t                 state, state_nxt;
  logic [N_CLIENTS-1:0]   pending, pending_nxt;
  logic [TIME_W-1:0]      time_q   [N_CLIENTS];
  logic [TIME_W-1:0]      time_nxt [N_CLIENTS];
  logic [IDX_W-1:0]       grant, grant_nxt;
  logic [IDX_W-1:0]       last_grant, last_grant_nxt;
  logic [WD_W-1:0]        wd, wd_nxt;
  logic                   request_start_nxt;
  logic [TIME_W-1:0]      requested_time_nxt;
  logic [N_CLIENTS-1:0]   client_done_nxt;
  logic                   timeout_nxt;
  logic [IDX_W-1:0]       rr_pick;
  logic                   rr_found;

  // Round-robin search starting just after the previous owner.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = last_grant;
    for (int unsigned k = 1; k <= N_CLIENTS; k++) begin
      if (!rr_found && pending[IDX_W'((32'(last_grant) + k) % N_CLIENTS)]) begin
        rr_found = 1'b1;
        rr_pick  = IDX_W'((32'(last_grant) + k) % N_CLIENTS);
      end
    end
  end

  always_comb begin
    state_nxt          = state;
    pending_nxt        = pending;
    time_nxt           = time_q;
    grant_nxt          = grant;
    last_grant_nxt     = last_grant;
    wd_nxt             = wd;
    request_start_nxt  = 1'b0;
    requested_time_nxt = '0;
    client_done_nxt    = '0;
    timeout_nxt        = 1'b0;

    case (state)
      S_IDLE: begin
        if (rr_found) begin
          grant_nxt = rr_pick;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        request_start_nxt  = 1'b1;
        requested_time_nxt = time_q[grant];
        wd_nxt             = WD_W'(time_q[grant]) + WD_W'(WD_MARGIN);
        state_nxt          = S_WAIT;
      end
      S_WAIT: begin
        // Expiry has priority over a same-cycle watchdog abort.
        if (timer_done) begin
          client_done_nxt[grant] = 1'b1;
          pending_nxt[grant]     = 1'b0;
          last_grant_nxt         = grant;
          state_nxt              = S_IDLE;
        end else if (startOfFrame) begin
          if (wd == '0) begin
            timeout_nxt        = 1'b1;
            pending_nxt[grant] = 1'b0;
            last_grant_nxt     = grant;
            state_nxt          = S_IDLE;
          end else begin
            wd_nxt = wd - WD_W'(1);
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Capture after the clear so a request on the completion cycle re-arms.
    for (int unsigned i = 0; i < N_CLIENTS; i++) begin
      if (client_req[i] && !pending_nxt[i]) begin
        pending_nxt[i] = 1'b1;
        time_nxt[i]    = client_time[4*i +: 4];
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state          <= S_IDLE;
      pending        <= '0;
      for (int unsigned i = 0; i < N_CLIENTS; i++) time_q[i] <= '0;
      grant          <= '0;
      last_grant     <= IDX_W'(N_CLIENTS - 1);
      wd             <= '0;
      request_start  <= 1'b0;
      requested_time <= '0;
      client_done    <= '0;
      timeout_err    <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_nxt;
      pending        <= pending_nxt;
      time_q         <= time_nxt;
      grant          <= grant_nxt;
      last_grant     <= last_grant_nxt;
      wd             <= wd_nxt;
      request_start  <= request_start_nxt;
      requested_time <= requested_time_nxt;
      client_done    <= client_done_nxt;
      timeout_err    <= timeout_nxt;
      busy           <= (state_nxt != S_IDLE);
    end
  end

  assign client_pending = pending;

endmodule

// File: tb/tb_countdown_request_arb.sv
// Scoreboard bench for countdown_request_arb: tasks push expected timer-side
// and client-side events; a negedge monitor pops and compares them.
module tb_countdown_request_arb;

  localparam int unsigned N = 4;

  logic           clk = 1'b0;
  logic           resetN = 1'b0;
  logic           startOfFrame = 1'b0;
  logic [N-1:0]   client_req = '0;
  logic [4*N-1:0] client_time = '0;
  logic           timer_done = 1'b0;
  logic           request_start;
  logic [3:0]     requested_time;
  logic [N-1:0]   client_done;
  logic [N-1:0]   client_pending;
  logic           busy;
  logic           timeout_err;

  int vectors = 0;
  int miscompares = 0;

  typedef enum int {EV_START, EV_DONE, EV_TMO} ev_kind_t;
  typedef struct { ev_kind_t kind; logic [7:0] val; } ev_t;
  ev_t exp_q[$];

  countdown_request_arb #(.N_CLIENTS(N), .WD_MARGIN(2)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .client_req(client_req), .client_time(client_time), .timer_done(timer_done),
    .request_start(request_start), .requested_time(requested_time),
    .client_done(client_done), .client_pending(client_pending),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  // Output monitor: every start/done/timeout pulse must match the next expected event.
  always @(negedge clk) begin
    ev_t got;
    ev_t exp;
    if (resetN) begin
      if (client_done != '0 && timeout_err) begin
        vectors++; miscompares++;
        $display("FAIL done_vs_timeout both high done=%b tmo=%b", client_done, timeout_err);
      end
      if ($countones(client_done) > 1) begin
        vectors++; miscompares++;
        $display("FAIL done_onehot got=%b", client_done);
      end
      if (request_start || client_done != '0 || timeout_err) begin
        got.kind = request_start ? EV_START : (timeout_err ? EV_TMO : EV_DONE);
        got.val  = request_start ? 8'(requested_time) : (timeout_err ? 8'd0 : 8'(client_done));
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_event kind=%0d val=%h at %0t", got.kind, got.val, $time);
        end else begin
          exp = exp_q.pop_front();
          if (got.kind !== exp.kind || got.val !== exp.val) begin
            miscompares++;
            $display("FAIL event_order got kind=%0d val=%h, expected kind=%0d val=%h at %0t",
                     got.kind, got.val, exp.kind, exp.val, $time);
          end
        end
      end
    end
  end

  function automatic void expect_ev(ev_kind_t k, logic [7:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endfunction

  task automatic cyc(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_req(int c, logic [3:0] t);
    client_req[c] = 1'b1;
    client_time[4*c +: 4] = t;
    cyc();
    client_req = '0;
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    cyc();
    startOfFrame = 1'b0;
  endtask

  task automatic timer_pulse();
    timer_done = 1'b1;
    cyc();
    timer_done = 1'b0;
  endtask

  task automatic wait_start(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc();
      seen = request_start;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL wait_start no request_start within 20 cycles at %0t", $time);
    end
  endtask

  // Wait for the issue of client c, check its time, then expire it.
  task automatic serve(int c, logic [3:0] t);
    logic seen;
    logic [N-1:0] exp_done;
    exp_done = N'(1) << c;
    wait_start(seen);
    vectors++;
    if (requested_time !== t) begin
      miscompares++;
      $display("FAIL serve_time client=%0d got=%0d expected=%0d", c, requested_time, t);
    end
    cyc();
    timer_pulse();
    vectors++;
    if (client_done !== exp_done) begin
      miscompares++;
      $display("FAIL serve_done client=%0d got=%b expected=%b", c, client_done, exp_done);
    end
  endtask

  task automatic test_reset();
    cyc(3);
    vectors++;
    if ({request_start, requested_time, client_done, client_pending, busy, timeout_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%b expected all zero",
               {request_start, requested_time, client_done, client_pending, busy, timeout_err});
    end
    resetN = 1'b1;
    cyc(2);
    vectors++;
    if (busy !== 1'b0 || client_pending !== '0) begin
      miscompares++;
      $display("FAIL post_reset_idle busy=%b pending=%b expected 0/0", busy, client_pending);
    end
  endtask

  task automatic test_single();
    expect_ev(EV_START, 8'd3);
    expect_ev(EV_DONE, 8'b0010);
    pulse_req(1, 4'd3);
    vectors++;
    if (client_pending !== 4'b0010) begin
      miscompares++;
      $display("FAIL single_pending got=%b expected=0010", client_pending);
    end
    cyc();
    vectors++;
    if (request_start !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_issue_cycle start=%b busy=%b expected 0/1", request_start, busy);
    end
    cyc();
    vectors++;
    if (request_start !== 1'b1 || requested_time !== 4'd3) begin
      miscompares++;
      $display("FAIL single_start start=%b time=%0d expected 1/3", request_start, requested_time);
    end
    cyc();
    vectors++;
    if (request_start !== 1'b0) begin
      miscompares++;
      $display("FAIL single_start_width start=%b expected 0", request_start);
    end
    repeat (3) begin frame(); cyc(); end
    timer_pulse();
    vectors++;
    if (client_done !== 4'b0010 || client_pending !== 4'b0000 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_done done=%b pending=%b busy=%b expected 0010/0000/0",
               client_done, client_pending, busy);
    end
    cyc();
    vectors++;
    if (client_done !== 4'b0000) begin
      miscompares++;
      $display("FAIL single_done_width got=%b expected=0000", client_done);
    end
  endtask

  task automatic test_round_robin();
    expect_ev(EV_START, 8'd0);
    expect_ev(EV_DONE, 8'b0001);
    pulse_req(0, 4'd0);
    serve(0, 4'd0);
    cyc();
    expect_ev(EV_START, 8'd6); expect_ev(EV_DONE, 8'b0100);
    expect_ev(EV_START, 8'd1); expect_ev(EV_DONE, 8'b1000);
    expect_ev(EV_START, 8'd4); expect_ev(EV_DONE, 8'b0001);
    client_time = {4'd1, 4'd6, 4'd0, 4'd4};
    client_req  = 4'b1101;
    cyc();
    client_req  = '0;
    vectors++;
    if (client_pending !== 4'b1101) begin
      miscompares++;
      $display("FAIL rr_pending got=%b expected=1101", client_pending);
    end
    serve(2, 4'd6);
    serve(3, 4'd1);
    serve(0, 4'd4);
  endtask

  task automatic test_watchdog();
    logic seen;
    expect_ev(EV_START, 8'd2);
    expect_ev(EV_TMO, 8'd0);
    expect_ev(EV_START, 8'd1);
    expect_ev(EV_DONE, 8'b0010);
    pulse_req(0, 4'd2);
    wait_start(seen);
    pulse_req(1, 4'd1);
    vectors++;
    if (client_pending !== 4'b0011) begin
      miscompares++;
      $display("FAIL wd_pending got=%b expected=0011", client_pending);
    end
    for (int f = 0; f < 4; f++) begin
      frame();
      vectors++;
      if (timeout_err !== 1'b0) begin
        miscompares++;
        $display("FAIL wd_early frame=%0d tmo=%b expected 0", f + 1, timeout_err);
      end
      cyc();
    end
    frame();
    vectors++;
    if (timeout_err !== 1'b1 || client_done !== '0 || client_pending !== 4'b0010) begin
      miscompares++;
      $display("FAIL wd_expire tmo=%b done=%b pending=%b expected 1/0000/0010",
               timeout_err, client_done, client_pending);
    end
    serve(1, 4'd1);
  endtask

  task automatic test_rerequest();
    logic seen;
    expect_ev(EV_START, 8'd5); expect_ev(EV_DONE, 8'b0100);
    expect_ev(EV_START, 8'd7); expect_ev(EV_DONE, 8'b0100);
    pulse_req(2, 4'd5);
    pulse_req(2, 4'd9);
    wait_start(seen);
    vectors++;
    if (requested_time !== 4'd5) begin
      miscompares++;
      $display("FAIL rereq_ignore got=%0d expected=5", requested_time);
    end
    cyc();
    client_req[2] = 1'b1;
    client_time[11:8] = 4'd7;
    timer_done = 1'b1;
    cyc();
    client_req = '0;
    timer_done = 1'b0;
    vectors++;
    if (client_done !== 4'b0100 || client_pending !== 4'b0100) begin
      miscompares++;
      $display("FAIL rereq_rearm done=%b pending=%b expected 0100/0100", client_done, client_pending);
    end
    serve(2, 4'd7);
  endtask

  task automatic test_spurious();
    logic seen;
    cyc(2);
    timer_pulse();
    vectors++;
    if ({client_done, timeout_err, request_start, busy} !== '0) begin
      miscompares++;
      $display("FAIL spurious_idle got=%b expected all zero", {client_done, timeout_err, request_start, busy});
    end
    cyc(3);
    expect_ev(EV_START, 8'd0);
    expect_ev(EV_DONE, 8'b1000);
    pulse_req(3, 4'd0);
    wait_start(seen);
    frame(); cyc();
    frame(); cyc();
    startOfFrame = 1'b1;
    timer_done = 1'b1;
    cyc();
    startOfFrame = 1'b0;
    timer_done = 1'b0;
    vectors++;
    if (client_done !== 4'b1000 || timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL simul_done_wins done=%b tmo=%b expected 1000/0", client_done, timeout_err);
    end
    cyc();
    vectors++;
    if (timeout_err !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL simul_after tmo=%b busy=%b expected 0/0", timeout_err, busy);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic seen;
    expect_ev(EV_START, 8'd9);
    pulse_req(1, 4'd9);
    wait_start(seen);
    cyc();
    resetN = 1'b0;
    #1;
    vectors++;
    if ({request_start, requested_time, client_done, client_pending, busy, timeout_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_wait got=%b expected all zero",
               {request_start, requested_time, client_done, client_pending, busy, timeout_err});
    end
    cyc(2);
    resetN = 1'b1;
    repeat (4) begin frame(); cyc(); timer_pulse(); cyc(); end
    vectors++;
    if ({client_pending, busy, client_done, timeout_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_quiet got=%b expected all zero", {client_pending, busy, client_done, timeout_err});
    end
    expect_ev(EV_START, 8'd4);
    expect_ev(EV_DONE, 8'b0001);
    pulse_req(0, 4'd4);
    serve(0, 4'd4);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_watchdog();
    test_rerequest();
    test_spurious();
    test_reset_mid_wait();
    cyc(3);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain %0d expected events never seen", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
